// File: rtl/stream_crop.sv
// stream_crop: crops a dtype-framed pixel stream to a rectangle.
// Window config is shadowed at FRAME_START; 1-cycle latency.
module stream_crop #(
  parameter int DATA_WIDTH  = 16,
  parameter int DIM_WIDTH   = 16,
  parameter int DTYPE_WIDTH = 4,
  parameter logic [DTYPE_WIDTH-1:0] DT_FRAME_START = DTYPE_WIDTH'(1),
  parameter logic [DTYPE_WIDTH-1:0] DT_FRAME_END   = DTYPE_WIDTH'(2),
  parameter logic [DTYPE_WIDTH-1:0] DT_ROW_START   = DTYPE_WIDTH'(3),
  parameter logic [DTYPE_WIDTH-1:0] DT_ROW_END     = DTYPE_WIDTH'(4),
  parameter logic [DTYPE_WIDTH-1:0] DT_PIXEL       = DTYPE_WIDTH'(5)
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   enable,
  input  logic [DIM_WIDTH-1:0]   row_start,
  input  logic [DIM_WIDTH-1:0]   col_start,
  input  logic [DIM_WIDTH-1:0]   num_rows,
  input  logic [DIM_WIDTH-1:0]   num_cols,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic [DATA_WIDTH-1:0]  datai,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [DATA_WIDTH-1:0]  datao
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    IN_ROW,
    BETWEEN_ROWS
  } state_t;

  state_t                 state_q, state_d;
  logic                   en_q, en_d;
  logic [DIM_WIDTH-1:0]   rs_q, rs_d;
  logic [DIM_WIDTH-1:0]   cs_q, cs_d;
  logic [DIM_WIDTH-1:0]   nr_q, nr_d;
  logic [DIM_WIDTH-1:0]   nc_q, nc_d;
  logic [DIM_WIDTH-1:0]   row_cnt_q, row_cnt_d;
  logic [DIM_WIDTH-1:0]   col_cnt_q, col_cnt_d;
  logic                   row_keep_q, row_keep_d;
  logic                   dvo_q, dvo_d;
  logic [DTYPE_WIDTH-1:0] dtypeo_q, dtypeo_d;
  logic [DATA_WIDTH-1:0]  datao_q, datao_d;

  logic row_hit;
  logic col_hit;
  logic fwd;

  // Window hit tests; subtraction only matters under the >= guard
  always_comb begin
    row_hit = (row_cnt_q >= rs_q) &&
              ((row_cnt_q - rs_q) < nr_q);
    col_hit = row_keep_q &&
              (col_cnt_q >= cs_q) &&
              ((col_cnt_q - cs_q) < nc_q);
  end

  // Next state, counters, shadows and forward decision
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    rs_d       = rs_q;
    cs_d       = cs_q;
    nr_d       = nr_q;
    nc_d       = nc_q;
    row_cnt_d  = row_cnt_q;
    col_cnt_d  = col_cnt_q;
    row_keep_d = row_keep_q;
    fwd        = 1'b0;
    if (dvi) begin
      if (dtypei == DT_FRAME_START) begin
        fwd        = 1'b1;
        en_d       = enable;
        rs_d       = row_start;
        cs_d       = col_start;
        nr_d       = num_rows;
        nc_d       = num_cols;
        row_cnt_d  = '0;
        col_cnt_d  = '0;
        row_keep_d = 1'b0;
        state_d    = HDR;
      end else begin
        unique case (state_q)
          IDLE: fwd = 1'b0;
          HDR, BETWEEN_ROWS: begin
            if (dtypei == DT_ROW_START) begin
              state_d    = IN_ROW;
              col_cnt_d  = '0;
              row_keep_d = row_hit;
              fwd        = row_hit | ~en_q;
            end else if (dtypei == DT_FRAME_END) begin
              state_d = IDLE;
              fwd     = 1'b1;
            end else begin
              fwd = 1'b1;
            end
          end
          IN_ROW: begin
            if (dtypei == DT_PIXEL) begin
              fwd = col_hit | ~en_q;
              if (col_cnt_q != '1)
                col_cnt_d = col_cnt_q + 1'b1;
            end else if (dtypei == DT_ROW_END) begin
              fwd     = row_keep_q | ~en_q;
              state_d = BETWEEN_ROWS;
              if (row_cnt_q != '1)
                row_cnt_d = row_cnt_q + 1'b1;
            end else if (dtypei == DT_FRAME_END) begin
              fwd     = 1'b1;
              state_d = IDLE;
            end else if (dtypei == DT_ROW_START) begin
              col_cnt_d  = '0;
              row_keep_d = row_hit;
              fwd        = row_hit | ~en_q;
            end else begin
              fwd = 1'b1;
            end
          end
          default: fwd = 1'b0;
        endcase
      end
    end
  end

  // Output word staging; type/data hold while nothing is forwarded
  always_comb begin
    dvo_d    = fwd;
    dtypeo_d = fwd ? dtypei : dtypeo_q;
    datao_d  = fwd ? datai : datao_q;
  end

  // State, counter, shadow and output registers
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      rs_q       <= '0;
      cs_q       <= '0;
      nr_q       <= '0;
      nc_q       <= '0;
      row_cnt_q  <= '0;
      col_cnt_q  <= '0;
      row_keep_q <= 1'b0;
      dvo_q      <= 1'b0;
      dtypeo_q   <= '0;
      datao_q    <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      rs_q       <= rs_d;
      cs_q       <= cs_d;
      nr_q       <= nr_d;
      nc_q       <= nc_d;
      row_cnt_q  <= row_cnt_d;
      col_cnt_q  <= col_cnt_d;
      row_keep_q <= row_keep_d;
      dvo_q      <= dvo_d;
      dtypeo_q   <= dtypeo_d;
      datao_q    <= datao_d;
    end
  end

  assign dvo    = dvo_q;
  assign dtypeo = dtypeo_q;
  assign datao  = datao_q;

endmodule

// File: tb/tb_stream_crop.sv
// tb_stream_crop: directed frames checked cycle by cycle
// against a frame-level model, plus literal window results.
module tb_stream_crop;

  localparam logic [3:0] T_FS = 4'd1;
  localparam logic [3:0] T_FE = 4'd2;
  localparam logic [3:0] T_RS = 4'd3;
  localparam logic [3:0] T_RE = 4'd4;
  localparam logic [3:0] T_PX = 4'd5;
  localparam logic [3:0] T_HD = 4'd6;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] row_start = '0;
  logic [15:0] col_start = '0;
  logic [15:0] num_rows = '0;
  logic [15:0] num_cols = '0;
  logic        dvi = 1'b0;
  logic [3:0]  dtypei = '0;
  logic [15:0] datai = '0;
  logic        dvo;
  logic [3:0]  dtypeo;
  logic [15:0] datao;

  always #5 clk = ~clk;

  stream_crop #(
    .DATA_WIDTH(16),
    .DIM_WIDTH(16),
    .DTYPE_WIDTH(4)
  ) dut (
    .clk(clk),
    .resetb(resetb),
    .enable(enable),
    .row_start(row_start),
    .col_start(col_start),
    .num_rows(num_rows),
    .num_cols(num_cols),
    .dvi(dvi),
    .dtypei(dtypei),
    .datai(datai),
    .dvo(dvo),
    .dtypeo(dtypeo),
    .datao(datao)
  );

  int n_pass = 0;
  int n_tot = 0;

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  nm, act, exp);
  endtask

  // Frame-level model state
  bit m_frame, m_inrow, m_byp, m_keep;
  int m_rs, m_cs, m_nr, m_nc, m_row, m_col;

  bit         nxt_v = 1'b0;
  logic [3:0] nxt_t = '0;
  logic [15:0] nxt_d = '0;
  bit         exp_v;
  logic [3:0] exp_t;
  logic [15:0] exp_d;
  bit         chk_on = 1'b0;

  // Per-frame log of what the DUT emitted
  int lw, lpix, lrs, lre, lfirst, llast;

  task automatic clr_log();
    lw = 0; lpix = 0; lrs = 0; lre = 0;
    lfirst = -1; llast = -1;
  endtask

  task automatic model(bit v, logic [3:0] t, logic [15:0] d);
    nxt_v = 1'b0;
    nxt_t = t;
    nxt_d = d;
    if (!v) begin
      nxt_v = 1'b0;
    end else if (t == T_FS) begin
      m_frame = 1; m_inrow = 0; m_row = 0; m_col = 0;
      m_byp = !enable;
      m_rs = row_start; m_cs = col_start;
      m_nr = num_rows;  m_nc = num_cols;
      nxt_v = 1'b1;
    end else if (!m_frame) begin
      nxt_v = 1'b0;
    end else if (t == T_FE) begin
      nxt_v = 1'b1;
      m_frame = 0;
      m_inrow = 0;
    end else if (t == T_RS) begin
      m_inrow = 1;
      m_col = 0;
      m_keep = (m_row >= m_rs) && (m_row < m_rs + m_nr);
      nxt_v = m_keep || m_byp;
    end else if (t == T_PX && m_inrow) begin
      nxt_v = m_byp ||
              (m_keep && m_col >= m_cs && m_col < m_cs + m_nc);
      if (m_col < 65535) m_col++;
    end else if (t == T_RE && m_inrow) begin
      nxt_v = m_keep || m_byp;
      if (m_row < 65535) m_row++;
      m_inrow = 0;
    end else begin
      nxt_v = 1'b1;
    end
  endtask

  // Expected output register: one cycle behind the model
  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      exp_v <= 1'b0;
      exp_t <= '0;
      exp_d <= '0;
    end else begin
      exp_v <= nxt_v;
      if (nxt_v) begin
        exp_t <= nxt_t;
        exp_d <= nxt_d;
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("dvo", int'(dvo), int'(exp_v));
      chk("dtypeo", int'(dtypeo), int'(exp_t));
      chk("datao", int'(datao), int'(exp_d));
      if (dvo) begin
        lw++;
        if (dtypeo == T_RS) lrs++;
        if (dtypeo == T_RE) lre++;
        if (dtypeo == T_PX) begin
          lpix++;
          if (lfirst < 0) lfirst = int'(datao);
          llast = int'(datao);
        end
      end
    end
  end

  task automatic step(bit v, logic [3:0] t, logic [15:0] d);
    @(negedge clk);
    dvi = v;
    dtypei = t;
    datai = d;
    model(v, t, d);
  endtask

  task automatic cfg(bit en, int rs, int cs, int nr, int nc);
    enable = en;
    row_start = 16'(rs);
    col_start = 16'(cs);
    num_rows = 16'(nr);
    num_cols = 16'(nc);
  endtask

  // 8-wide ramp frames; optional truncation and mid-frame
  // col_start change before row chg_row
  task automatic frame(int rows, int cols, int nhdr,
                       int tr_row, int tr_col,
                       int chg_row, int chg_cs);
    clr_log();
    step(1, T_FS, 16'hF000);
    for (int h = 0; h < nhdr; h++)
      step(1, T_HD, 16'(16'hA000 + h));
    for (int r = 0; r < rows; r++) begin
      if (r == chg_row) col_start = 16'(chg_cs);
      step(1, T_RS, 16'h0000);
      for (int c = 0; c < cols; c++) begin
        if (r == tr_row && c == tr_col) begin
          step(1, T_FE, 16'hFE00);
          step(0, '0, '0);
          step(0, '0, '0);
          return;
        end
        step(1, T_PX, 16'(r * 16 + c));
      end
      step(1, T_RE, 16'h0000);
      step(0, T_PX, 16'hDEAD);
    end
    step(1, T_FE, 16'hFE00);
    step(0, '0, '0);
    step(0, '0, '0);
  endtask

  initial begin
    m_frame = 0; m_inrow = 0; m_byp = 0; m_keep = 0;
    m_rs = 0; m_cs = 0; m_nr = 0; m_nc = 0;
    m_row = 0; m_col = 0;
    clr_log();
    #12;
    chk("reset_dvo", int'(dvo), 0);
    chk("reset_dtypeo", int'(dtypeo), 0);
    chk("reset_datao", int'(datao), 0);
    @(negedge clk);
    resetb = 1'b1;
    chk_on = 1'b1;

    // Words before any FRAME_START are dropped
    clr_log();
    step(1, T_PX, 16'h0055);
    step(1, T_HD, 16'h0066);
    step(0, '0, '0);
    step(0, '0, '0);
    chk("idle_drop_words", lw, 0);

    // Bypass
    cfg(0, 1, 2, 3, 4);
    frame(6, 8, 2, -1, 0, -1, 0);
    chk("bypass_words", lw, 64);
    chk("bypass_pix", lpix, 48);

    // Basic crop
    cfg(1, 1, 2, 3, 4);
    frame(6, 8, 2, -1, 0, -1, 0);
    chk("crop_words", lw, 22);
    chk("crop_pix", lpix, 12);
    chk("crop_first", lfirst, 'h012);
    chk("crop_last", llast, 'h035);
    chk("crop_rows", lrs, 3);

    // Edge clip
    cfg(1, 4, 6, 10, 10);
    frame(6, 8, 2, -1, 0, -1, 0);
    chk("clip_pix", lpix, 4);
    chk("clip_first", lfirst, 'h046);
    chk("clip_last", llast, 'h057);
    chk("clip_rows", lrs, 2);

    // Empty windows
    cfg(1, 0, 0, 6, 0);
    frame(6, 8, 2, -1, 0, -1, 0);
    chk("nocols_rs", lrs, 6);
    chk("nocols_re", lre, 6);
    chk("nocols_pix", lpix, 0);
    cfg(1, 0, 0, 0, 8);
    frame(6, 8, 2, -1, 0, -1, 0);
    chk("norows_words", lw, 4);

    // col_start past the row: kept rows with no pixels
    cfg(1, 0, 9, 2, 4);
    frame(6, 8, 0, -1, 0, -1, 0);
    chk("farcol_rs", lrs, 2);
    chk("farcol_pix", lpix, 0);

    // Shadowing: change lands mid-frame A, used by frame B
    cfg(1, 1, 2, 3, 4);
    frame(6, 8, 2, -1, 0, 3, 0);
    chk("shadowA_first", lfirst, 'h012);
    chk("shadowA_last", llast, 'h035);
    frame(6, 8, 2, -1, 0, -1, 0);
    chk("shadowB_first", lfirst, 'h010);
    chk("shadowB_last", llast, 'h033);

    // Truncated frame then stray words in IDLE
    cfg(1, 1, 2, 3, 4);
    frame(6, 8, 2, 3, 4, -1, 0);
    chk("trunc_pix", lpix, 10);
    chk("trunc_last", llast, 'h033);
    chk("trunc_rs", lrs, 3);
    chk("trunc_re", lre, 2);
    chk("trunc_words", lw, 19);
    step(1, T_PX, 16'h0077);
    step(1, T_RS, 16'h0000);
    step(0, '0, '0);
    step(0, '0, '0);
    chk("trunc_idle_words", lw, 19);
    frame(6, 8, 2, -1, 0, -1, 0);
    chk("after_trunc_pix", lpix, 12);

    // Restarted row re-evaluates the same row
    cfg(1, 0, 1, 1, 2);
    clr_log();
    step(1, T_FS, 16'hF000);
    step(1, T_RS, 16'h0);
    step(1, T_PX, 16'h0100);
    step(1, T_RS, 16'h0);
    step(1, T_PX, 16'h0200);
    step(1, T_PX, 16'h0201);
    step(1, T_RE, 16'h0);
    step(1, T_FE, 16'hFE00);
    step(0, '0, '0);
    step(0, '0, '0);
    chk("restart_pix", lpix, 1);
    chk("restart_first", lfirst, 'h0201);

    // Reset pulse mid-row
    cfg(1, 0, 0, 6, 8);
    step(1, T_FS, 16'hF000);
    step(1, T_RS, 16'h0);
    step(1, T_PX, 16'h0000);
    step(1, T_PX, 16'h0001);
    @(posedge clk);
    #2;
    chk("pre_reset_dvo", int'(dvo), 1);
    resetb = 1'b0;
    dvi = 1'b0;
    nxt_v = 1'b0;
    m_frame = 0;
    m_inrow = 0;
    #1;
    chk("async_reset_dvo", int'(dvo), 0);
    chk("async_reset_datao", int'(datao), 0);
    @(negedge clk);
    resetb = 1'b1;
    clr_log();
    step(1, T_PX, 16'h0002);
    step(1, T_PX, 16'h0003);
    step(1, T_RE, 16'h0);
    step(1, T_RS, 16'h0);
    step(1, T_FE, 16'hFE00);
    step(0, '0, '0);
    step(0, '0, '0);
    chk("post_reset_drop", lw, 0);
    cfg(1, 1, 2, 3, 4);
    frame(6, 8, 2, -1, 0, -1, 0);
    chk("post_reset_pix", lpix, 12);
    chk("post_reset_first", lfirst, 'h012);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/stream_crop.md
Name: stream_crop

Overview:
- Windowing stage directly downstream of imager_rx; consumes its dvo/dtypeo/datao stream and feeds rotate/filter2d/stream2di.
- Passes only the pixels inside a programmable rectangle (row_start, col_start, num_rows, num_cols).
- Emits a well-formed, smaller frame in the same dtype protocol; frame markers and header words pass unchanged.
- Window config is shadowed at frame start, so register writes never tear a frame.

Parameters:
- DATA_WIDTH, 16, width of datai/datao (pixel in LSBs, header words full width)
- DIM_WIDTH, 16, width of the window config and of the internal row/col counters

Ports:
- clk  input  1  pixel clock; all logic on posedge
- resetb  input  1  asynchronous active-low reset
- enable  input  1  0 = bypass (input registered straight to output); 1 = crop
- row_start  input  DIM_WIDTH  first kept row, 0-based
- col_start  input  DIM_WIDTH  first kept column, 0-based
- num_rows  input  DIM_WIDTH  kept row count
- num_cols  input  DIM_WIDTH  kept column count
- dvi  input  1  input word valid
- dtypei  input  `DTYPE_WIDTH  input word type (dtypes.v codes)
- datai  input  DATA_WIDTH  input word
- dvo  output  1  output word valid
- dtypeo  output  `DTYPE_WIDTH  output word type
- datao  output  DATA_WIDTH  output word

Behaviour:
- Reset (async assert, sync release): dvo=0, dtypeo=0, datao=0; state=IDLE; row/col counters and shadow registers = 0.
- Latency: exactly 1 cycle for every forwarded word. No backpressure; a dropped word gives dvo=0 on that output cycle. dtypeo/datao update only when dvo=1.
- Bypass (enable=0 when FRAME_START is sampled): every dvi word is forwarded unchanged for the whole frame. enable is sampled only at FRAME_START.
- States and transitions:
  - IDLE: all words dropped except `DTYPE_FRAME_START.
  - FRAME_START -> HDR: forward the word; latch enable, row_start, col_start, num_rows, num_cols into shadows; row_cnt=0.
  - HDR / BETWEEN_ROWS:
    - ROW_START -> IN_ROW; col_cnt=0; row_keep = (row_cnt >= row_start) && (row_cnt - row_start < num_rows). Forward ROW_START only if row_keep.
    - FRAME_END -> IDLE; always forwarded.
    - Any other dtype (header words) is forwarded unchanged.
  - IN_ROW:
    - PIXEL: forward if row_keep && col_cnt >= col_start && (col_cnt - col_start) < num_cols; col_cnt++ (saturates at all-ones).
    - ROW_END: forward if row_keep; row_cnt++ (saturating); go to BETWEEN_ROWS.
    - FRAME_END: truncated frame. Forwarded, no ROW_END inserted, go to IDLE.
- Compare rule: all compares unsigned at DIM_WIDTH. Subtractions are evaluated only under the >= guard, so no wrap.
- Boundary conditions:
  - num_rows=0 or num_cols=0: no kept rows or no kept pixels. Frame markers and headers still emitted.
  - Window past the image edge: clipped naturally; no padding.
  - col_start >= row length: kept rows are emitted as ROW_START/ROW_END with no pixels.
  - FRAME_START while not IDLE: treated as a new frame. Re-latch shadows, counters cleared, word forwarded.
  - ROW_START while IN_ROW: restart the row. col_cnt=0, row_keep re-evaluated with the same row_cnt.
  - Config changes mid-frame: no effect until the next FRAME_START.
  - resetb asserted mid-frame: outputs 0 immediately. After release, input is ignored until the next FRAME_START.
- dvi=0: no state change, dvo=0 next cycle.

Test Plan:
- Bypass: enable=0, 8x6 frame, 2 header words -> output identical to input delayed 1 cycle, word for word.
- Basic crop: enable=1, 8x6 ramp (pixel = row*16+col), row_start=1, col_start=2, num_rows=3, num_cols=4.
  - Output: FRAME_START, 2 headers, 3 rows of 4 pixels, FRAME_END.
  - First pixel 0x012, last 0x035; every word 1 cycle after its input.
- Edge clip: 8x6, row_start=4, col_start=6, num_rows=10, num_cols=10 -> rows 4-5 kept, cols 6-7 kept; 2 rows x 2 pixels.
- Empty window: num_cols=0 -> 6 ROW_START/ROW_END pairs, zero PIXEL words. num_rows=0 -> only FRAME_START, headers, FRAME_END.
- Config shadowing: change col_start 2->0 after row 2 of frame A -> frame A uses 2 throughout; frame B uses 0.
- Truncation/reset:
  - FRAME_END mid-row 3 -> FRAME_END forwarded, no ROW_END, state IDLE; next frame crops correctly.
  - resetb pulsed mid-row -> dvo=0 asynchronously; pixels dropped until the next FRAME_START.
